// File: rtl/axi_sram_slave_if.sv
// AXI4 bus bundle between the interconnect's slave 0 port and the SRAM
// endpoint. The slave modport is the memory side; master is the driver side.
interface axi_sram_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  // Write address channel
  logic [ID_WIDTH-1:0]   AWID;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [1:0]            AWBURST;
  logic                  AWVALID;
  logic                  AWREADY;
  // Write data channel
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WLAST;
  logic                  WVALID;
  logic                  WREADY;
  // Write response channel
  logic [ID_WIDTH-1:0]   BID;
  logic [1:0]            BRESP;
  logic [USER_WIDTH-1:0] BUSER;
  logic                  BVALID;
  logic                  BREADY;
  // Read address channel
  logic [ID_WIDTH-1:0]   ARID;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [1:0]            ARBURST;
  logic                  ARVALID;
  logic                  ARREADY;
  // Read data channel
  logic [ID_WIDTH-1:0]   RID;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RLAST;
  logic [USER_WIDTH-1:0] RUSER;
  logic                  RVALID;
  logic                  RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BUSER, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BUSER, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RUSER, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 SRAM endpoint: one transaction at a time, INCR/FIXED bursts (WRAP is
// walked like INCR), byte-strobe writes, SLVERR for words beyond MEM_DEPTH.
// All ready/valid and response outputs are forced low while ARESETn is low.
module axi_sram_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  axi_sram_slave_if.slave  s_axi
);
  localparam int SHIFT = $clog2(STRB_WIDTH);
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(MEM_DEPTH);
  localparam logic [1:0]            BURST_FIXED = 2'b00;
  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [7:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [8:0]            beat_q, beat_d;   // 9 bits so len = 255 cannot wrap
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  in_range_s, last_beat_s, mem_we_s;
  logic [IDX_W-1:0]      mem_addr_s;
  logic [ADDR_WIDTH-1:0] idx_next_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

  logic                  arready_s, awready_s, wready_s, rvalid_s, bvalid_s, rlast_s;
  logic [ID_WIDTH-1:0]   rid_s, bid_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic [1:0]            rresp_s, bresp_s;

  // The range check uses the full index, so a wrapped index is still checked.
  assign in_range_s  = (idx_q < DEPTH_A);
  assign mem_addr_s  = idx_q[IDX_W-1:0];
  assign last_beat_s = (beat_q == {1'b0, len_q});
  assign idx_next_s  = (burst_q == BURST_FIXED) ? idx_q : (idx_q + ADDR_WIDTH'(1));
  assign rd_word_s   = in_range_s ? mem_q[mem_addr_s] : {DATA_WIDTH{1'b0}};

  // Next-state, captured-field updates and channel outputs for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    idx_d     = idx_q;
    len_d     = len_q;
    burst_d   = burst_q;
    beat_d    = beat_q;
    err_d     = err_q;
    mem_we_s  = 1'b0;
    arready_s = 1'b0;
    awready_s = 1'b0;
    wready_s  = 1'b0;
    rvalid_s  = 1'b0;
    bvalid_s  = 1'b0;
    rlast_s   = 1'b0;
    rid_s     = {ID_WIDTH{1'b0}};
    bid_s     = {ID_WIDTH{1'b0}};
    rdata_s   = {DATA_WIDTH{1'b0}};
    rresp_s   = RESP_OKAY;
    bresp_s   = RESP_OKAY;
    if (!ARESETn) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          arready_s = 1'b1;
          awready_s = !s_axi.ARVALID;  // reads win a same-cycle request
          if (s_axi.ARVALID) begin
            id_d    = s_axi.ARID;
            idx_d   = s_axi.ARADDR >> SHIFT;
            len_d   = s_axi.ARLEN;
            burst_d = s_axi.ARBURST;
            beat_d  = 9'd0;
            state_d = S_RD;
          end else if (s_axi.AWVALID) begin
            id_d    = s_axi.AWID;
            idx_d   = s_axi.AWADDR >> SHIFT;
            len_d   = s_axi.AWLEN;
            burst_d = s_axi.AWBURST;
            beat_d  = 9'd0;
            err_d   = 1'b0;
            state_d = S_WR;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_RD: begin
          rvalid_s = 1'b1;
          rid_s    = id_q;
          rdata_s  = rd_word_s;
          rresp_s  = in_range_s ? RESP_OKAY : RESP_SLVERR;
          rlast_s  = last_beat_s;
          if (s_axi.RREADY) begin
            beat_d  = beat_q + 9'd1;
            idx_d   = idx_next_s;
            state_d = last_beat_s ? S_IDLE : S_RD;
          end else begin
            state_d = S_RD;
          end
        end
        S_WR: begin
          wready_s = 1'b1;
          if (s_axi.WVALID) begin
            beat_d = beat_q + 9'd1;
            idx_d  = idx_next_s;
            if (beat_q > {1'b0, len_q}) begin
              err_d = 1'b1;          // beat beyond AWLEN is dropped
            end else if (!in_range_s) begin
              err_d = 1'b1;
            end else begin
              mem_we_s = 1'b1;
            end
            if (s_axi.WLAST) begin
              state_d = S_WB;
              if (!last_beat_s) begin
                err_d = 1'b1;        // WLAST did not line up with AWLEN
              end else begin
                err_d = err_d;
              end
            end else begin
              state_d = S_WR;
            end
          end else begin
            state_d = S_WR;
          end
        end
        S_WB: begin
          bvalid_s = 1'b1;
          bid_s    = id_q;
          bresp_s  = err_q ? RESP_SLVERR : RESP_OKAY;
          state_d  = s_axi.BREADY ? S_IDLE : S_WB;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and captured transaction fields; a low ARESETn at the edge clears them.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      id_q    <= {ID_WIDTH{1'b0}};
      idx_q   <= {ADDR_WIDTH{1'b0}};
      len_q   <= 8'd0;
      burst_q <= 2'b00;
      beat_q  <= 9'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge ACLK) begin
    if (mem_we_s) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_axi.WSTRB[b]) begin
          mem_q[mem_addr_s][b*8 +: 8] <= s_axi.WDATA[b*8 +: 8];
        end
      end
    end
  end

  assign s_axi.ARREADY = arready_s;
  assign s_axi.AWREADY = awready_s;
  assign s_axi.WREADY  = wready_s;
  assign s_axi.RVALID  = rvalid_s;
  assign s_axi.RID     = rid_s;
  assign s_axi.RDATA   = rdata_s;
  assign s_axi.RRESP   = rresp_s;
  assign s_axi.RLAST   = rlast_s;
  assign s_axi.RUSER   = {USER_WIDTH{1'b0}};
  assign s_axi.BVALID  = bvalid_s;
  assign s_axi.BID     = bid_s;
  assign s_axi.BRESP   = bresp_s;
  assign s_axi.BUSER   = {USER_WIDTH{1'b0}};
endmodule
